gru_mac_sequencer: RTL
======================

Name: gru_mac_sequencer

Overview:
- Sequences the shared FP adder and FP multiplier to compute one GRU gate pre-activation: result = bias + sum(w[i]*x[i]) for i = 0..len-1.
- Reads weight/input pairs from external single-port buffers with 1-cycle read latency.
- Drives the adder and multiplier start/done handshakes.
- Sits between the GRU layer controller (above) and the FP datapath units (below).

Parameters:
- DATA_WIDTH, 32, IEEE-754 single-precision operand/result width.
- ADDR_WIDTH, 4, buffer address width.
- N_MAX, 16, maximum term count; must be <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- len  in  ADDR_WIDTH+1  number of terms; sampled with start.
- bias  in  DATA_WIDTH  bias value; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when result is valid.
- result  out  DATA_WIDTH  final accumulated value; held until the next accepted start.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  ADDR_WIDTH  term index.
- w_rdata  in  DATA_WIDTH  weight; valid the cycle after rd_en.
- x_rdata  in  DATA_WIDTH  input; valid the cycle after rd_en.
- mult_start  out  1  one-cycle multiplier start.
- mult_w  out  DATA_WIDTH  multiplier operand w.
- mult_x  out  DATA_WIDTH  multiplier operand x.
- mult_done  in  1  multiplier completion pulse.
- mult_result  in  DATA_WIDTH  product; valid while mult_done is high.
- add_start  out  1  one-cycle adder start.
- add_a  out  DATA_WIDTH  adder operand a (accumulator).
- add_b  out  DATA_WIDTH  adder operand b (product).
- add_done  in  1  adder completion pulse.
- add_result  in  DATA_WIDTH  sum; valid while add_done is high.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0: busy, done, result, rd_en, rd_addr, mult_start, mult_w, mult_x, add_start, add_a, add_b.
  - Internal acc, idx and cnt go to 0.
  - Reset mid-operation aborts the job. In-flight unit done pulses arriving afterwards are ignored.
- FSM states: IDLE, FETCH, RD_WAIT, MUL_START, MUL_WAIT, ADD_START, ADD_WAIT, FIN.
- IDLE:
  - On start, latch acc<=bias, idx<=0 and cnt<=min(len,N_MAX).
  - Next state is FIN if the clamped len==0, else FETCH.
  - start in any other state is ignored.
- FETCH: rd_en=1 and rd_addr=idx for exactly one cycle; go to RD_WAIT.
- RD_WAIT: register mult_w<=w_rdata and mult_x<=x_rdata; go to MUL_START.
- MUL_START: mult_start=1 for one cycle; go to MUL_WAIT.
- MUL_WAIT:
  - Stay until mult_done=1.
  - On that cycle, add_a<=acc, add_b<=mult_result; go to ADD_START.
- ADD_START: add_start=1 for one cycle; go to ADD_WAIT.
- ADD_WAIT:
  - Stay until add_done=1.
  - On that cycle, acc<=add_result and idx<=idx+1.
  - If idx+1==cnt, go to FIN; else go to FETCH.
- FIN: result<=acc and done=1 for one cycle; busy drops to 0 in the same cycle; go to IDLE.
- Operand stability: mult_w/mult_x are held stable from MUL_START until the next RD_WAIT. add_a/add_b are held stable from ADD_START until the next MUL_WAIT exit.
- Unit done pulses are honoured only in the matching WAIT state; they are ignored elsewhere.
- Only one unit is active at a time; there is no overlap between terms.
- Latency: Lm = cycles from the mult_start cycle (exclusive) to the mult_done cycle (inclusive); La is defined likewise for the adder.
  - Per-term cost: 4+Lm+La cycles.
  - Total, start to done: 1 + len*(4+Lm+La) + 1 cycles.
  - len=0: done 2 cycles after start (IDLE -> FIN).
- len > N_MAX is clamped to N_MAX.
- The block performs no FP arithmetic itself. Results are exactly what the units return.

Test Plan:
- len=3, w={0x3F800000,0x40000000,0x40400000}, x={0x40800000,0x40A00000,0x40C00000}, bias=0x3F000000, Lm=La=3 -> result=0x42020000 (32.5); done high exactly one cycle, 1+3*10+1=32 cycles after start; rd_addr sequence 0,1,2.
- len=0, bias=0x3F000000 -> no rd_en/mult_start/add_start; done 2 cycles after start; result=0x3F000000.
- start pulsed again while busy with len=5 -> ignored; first job completes with its original result; no extra done.
- rstn low for one cycle during MUL_WAIT of term 1, then mult_done fires -> all outputs 0, state IDLE, the stray done is ignored; a fresh len=1 job (w=2.0, x=4.0, bias=0) returns 0x41000000.
- Spurious mult_done/add_done pulses in IDLE and FETCH -> no state change, acc unchanged, final result matches the golden value.
- len=31 (> N_MAX=16), all w=x=1.0, bias=0 -> exactly 16 reads (addr 0..15); result=0x41800000 (16.0).

Source files
------------

// File: rtl/gru_mac_sequencer.sv
// Sequences shared FP multiplier/adder units to compute one GRU gate pre-activation:
// result = bias + sum(w[i]*x[i]), one term at a time, no overlap between units.
module gru_mac_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int N_MAX      = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] w_rdata,
  input  logic [DATA_WIDTH-1:0] x_rdata,
  output logic                  mult_start,
  output logic [DATA_WIDTH-1:0] mult_w,
  output logic [DATA_WIDTH-1:0] mult_x,
  input  logic                  mult_done,
  input  logic [DATA_WIDTH-1:0] mult_result,
  output logic                  add_start,
  output logic [DATA_WIDTH-1:0] add_a,
  output logic [DATA_WIDTH-1:0] add_b,
  input  logic                  add_done,
  input  logic [DATA_WIDTH-1:0] add_result
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] NMAX_C = CW'(N_MAX);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FETCH     = 3'd1;
  localparam logic [2:0] RD_WAIT   = 3'd2;
  localparam logic [2:0] MUL_START = 3'd3;
  localparam logic [2:0] MUL_WAIT  = 3'd4;
  localparam logic [2:0] ADD_START = 3'd5;
  localparam logic [2:0] ADD_WAIT  = 3'd6;
  localparam logic [2:0] FIN       = 3'd7;

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] acc;
  logic [CW-1:0]         idx, cnt, len_clamped, idx_nxt;

  assign len_clamped = (len > NMAX_C) ? NMAX_C : len;
  assign idx_nxt     = idx + CW'(1);

  // Strobes decode straight from state so the buffer read lands in RD_WAIT
  assign rd_en      = (state == FETCH);
  assign rd_addr    = idx[ADDR_WIDTH-1:0];
  assign mult_start = (state == MUL_START);
  assign add_start  = (state == ADD_START);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      mult_w <= '0;
      mult_x <= '0;
      add_a  <= '0;
      add_b  <= '0;
      acc    <= '0;
      idx    <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          acc   <= bias;
          idx   <= '0;
          cnt   <= len_clamped;
          busy  <= 1'b1;
          state <= (len_clamped == '0) ? FIN : FETCH;
        end
        FETCH:     state <= RD_WAIT;
        RD_WAIT: begin
          mult_w <= w_rdata;
          mult_x <= x_rdata;
          state  <= MUL_START;
        end
        MUL_START: state <= MUL_WAIT;
        MUL_WAIT: if (mult_done) begin
          add_a <= acc;
          add_b <= mult_result;
          state <= ADD_START;
        end
        ADD_START: state <= ADD_WAIT;
        ADD_WAIT: if (add_done) begin
          acc   <= add_result;
          idx   <= idx_nxt;
          state <= (idx_nxt == cnt) ? FIN : FETCH;
        end
        FIN: begin
          result <= acc;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
